imem_boot_ctrl: RTL and testbench

- Boot/load controller and arbiter for the word-addressed instruction memory.
- After reset it clears every word to the NOP encoding, then accepts program words from a host loader port, then hands the memory to the CPU fetch path and releases the CPU.
- Sits between the host/testbench program loader, the CPU PC, and the instruction storage array.

---
 rtl/imem_pkg.sv | 18 +
 rtl/imem_array.sv | 27 ++
 rtl/imem_boot_ctrl.sv | 149 ++++++++++++++
 tb/tb_imem_boot_ctrl.sv | 306 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/imem_pkg.sv
// Shared instruction-memory definitions: boot states, geometry and the NOP fill word.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package imem_pkg;

    localparam int IMEM_DEPTH  = 1024;
    localparam int IMEM_ADDR_W = $clog2(IMEM_DEPTH);

    // All-ones word is the NOP encoding; decode treats it the same way.
    localparam logic [31:0] NOP_WORD = 32'hFFFF_FFFF;

    typedef enum logic [1:0] {
        ST_CLEAR = 2'd0,
        ST_LOAD  = 2'd1,
        ST_RUN   = 2'd2
    } imem_state_t;

endpackage

// File: rtl/imem_array.sv
// Instruction storage: DEPTH x 32 words, one synchronous write port, one asynchronous read port.
// Latency: write lands at the next rising clk; read is combinational from raddr.
// Backpressure: none, a write is accepted every cycle we is high.
module imem_array #(
    parameter int DEPTH  = 1024,
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [31:0]       wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [31:0]       rdata
);

    logic [31:0] mem [DEPTH];

    // Storage is deliberately not reset; the boot controller clears it.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/imem_boot_ctrl.sv
// Boot/load controller: clears imem to NOP, accepts host loader writes, then releases the CPU fetch path.
// Latency: loader write lands next clk; fetch is combinational; state changes take effect next clk.
// Backpressure: ld_ready only in LOAD; writes offered in CLEAR/RUN are not taken.
module imem_boot_ctrl
    import imem_pkg::*;
#(
    parameter int          DEPTH    = imem_pkg::IMEM_DEPTH,
    parameter int          ADDR_W   = imem_pkg::IMEM_ADDR_W,
    parameter logic [31:0] NOP_WORD = imem_pkg::NOP_WORD
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            load_req,
    input  logic            ld_valid,
    output logic            ld_ready,
    input  logic [31:0]     ld_addr,
    input  logic [31:0]     ld_data,
    input  logic            ld_done,
    input  logic [31:0]     cpu_pc,
    output logic [31:0]     cpu_instr,
    output logic            cpu_run,
    output logic [ADDR_W:0] ld_count,
    output logic            ld_err,
    output logic            fetch_fault
);

    localparam logic [31:0]       DEPTH_W  = 32'(DEPTH);
    localparam logic [ADDR_W:0]   CNT_MAX  = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W-1:0] CLR_LAST = ADDR_W'(DEPTH - 1);

    imem_state_t       state;
    logic [ADDR_W-1:0] clr_idx;

    logic              ld_fire;
    logic              ld_in_range;
    logic              pc_in_range;

    logic              mem_we;
    logic [ADDR_W-1:0] mem_waddr;
    logic [31:0]       mem_wdata;
    logic [31:0]       mem_rdata;

    // Range checks use the full 32-bit index so high garbage bits never alias into the array.
    assign ld_in_range = (ld_addr < DEPTH_W);
    assign pc_in_range = (cpu_pc < DEPTH_W);
    assign ld_fire     = ld_valid & ld_ready;

    // Single write port arbitration: CLEAR owns it for the fill, LOAD for the host, RUN never writes.
    always_comb begin
        mem_we    = 1'b0;
        mem_waddr = clr_idx;
        mem_wdata = NOP_WORD;
        case (state)
            ST_CLEAR: begin
                mem_we = 1'b1;
            end
            ST_LOAD: begin
                mem_we    = ld_fire & ld_in_range;
                mem_waddr = ld_addr[ADDR_W-1:0];
                mem_wdata = ld_data;
            end
            default: begin
                mem_we = 1'b0;
            end
        endcase
    end

    // Boot sequencing FSM with registered handshake/run outputs and load bookkeeping.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= ST_CLEAR;
            clr_idx  <= '0;
            ld_ready <= 1'b0;
            cpu_run  <= 1'b0;
            ld_count <= '0;
            ld_err   <= 1'b0;
        end else begin
            case (state)
                ST_CLEAR: begin
                    clr_idx <= clr_idx + ADDR_W'(1);
                    if (clr_idx == CLR_LAST) begin
                        state    <= ST_LOAD;
                        clr_idx  <= '0;
                        ld_ready <= 1'b1;
                        ld_count <= '0;
                    end
                end
                ST_LOAD: begin
                    if (ld_fire) begin
                        if (ld_in_range) begin
                            if (ld_count != CNT_MAX) begin
                                ld_count <= ld_count + (ADDR_W+1)'(1);
                            end
                        end else begin
                            ld_err <= 1'b1;
                        end
                    end
                    // A write offered alongside ld_done is still taken above before leaving.
                    if (ld_done) begin
                        state    <= ST_RUN;
                        ld_ready <= 1'b0;
                        cpu_run  <= 1'b1;
                    end
                end
                ST_RUN: begin
                    // Re-entering LOAD keeps the existing program; only the count restarts.
                    if (load_req) begin
                        state    <= ST_LOAD;
                        ld_ready <= 1'b1;
                        cpu_run  <= 1'b0;
                        ld_count <= '0;
                    end
                end
                default: begin
                    state    <= ST_CLEAR;
                    clr_idx  <= '0;
                    ld_ready <= 1'b0;
                    cpu_run  <= 1'b0;
                end
            endcase
        end
    end

    // Fetch path: only RUN sees memory; anything else, or an out-of-range PC, yields NOP.
    always_comb begin
        cpu_instr   = NOP_WORD;
        fetch_fault = 1'b0;
        if (state == ST_RUN) begin
            if (pc_in_range) begin
                cpu_instr = mem_rdata;
            end else begin
                fetch_fault = 1'b1;
            end
        end
    end

    imem_array #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_imem_array (
        .clk   (clk),
        .we    (mem_we),
        .waddr (mem_waddr),
        .wdata (mem_wdata),
        .raddr (cpu_pc[ADDR_W-1:0]),
        .rdata (mem_rdata)
    );

endmodule

// File: tb/tb_imem_boot_ctrl.sv
// Bench for imem_boot_ctrl: directed boot/load/run sequence plus randomized load/fetch rounds.
// Expected responses come from an array-based model and are queued at issue time.
// A negedge monitor pops and compares whenever the stimulus flags an observation point.
module tb_imem_boot_ctrl;

    localparam int          DEPTH = 1024;
    localparam logic [31:0] NOP   = 32'hFFFF_FFFF;

    logic        clk = 1'b0;
    logic        reset;
    logic        load_req;
    logic        ld_valid;
    logic        ld_ready;
    logic [31:0] ld_addr;
    logic [31:0] ld_data;
    logic        ld_done;
    logic [31:0] cpu_pc;
    logic [31:0] cpu_instr;
    logic        cpu_run;
    logic [10:0] ld_count;
    logic        ld_err;
    logic        fetch_fault;

    imem_boot_ctrl dut (
        .clk         (clk),
        .reset       (reset),
        .load_req    (load_req),
        .ld_valid    (ld_valid),
        .ld_ready    (ld_ready),
        .ld_addr     (ld_addr),
        .ld_data     (ld_data),
        .ld_done     (ld_done),
        .cpu_pc      (cpu_pc),
        .cpu_instr   (cpu_instr),
        .cpu_run     (cpu_run),
        .ld_count    (ld_count),
        .ld_err      (ld_err),
        .fetch_fault (fetch_fault)
    );

    always #5 clk = ~clk;

    // Reference model: phase, program image, load count and sticky error.
    typedef enum int { M_CLEAR, M_LOAD, M_RUN } mphase_t;
    mphase_t     m_phase;
    logic [31:0] m_mem [DEPTH];
    int          m_cnt;
    logic        m_err;

    typedef struct {
        logic [31:0] instr;
        logic        fault;
        logic        run;
        logic        ready;
        logic [10:0] count;
        logic        err;
    } exp_t;

    exp_t exp_q[$];
    logic obs_vld = 1'b0;
    int   checks  = 0;
    int   errors  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Monitor: compares every DUT output against the oldest queued expectation.
    always @(negedge clk) begin
        if (obs_vld) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL scoreboard_underflow: got empty queue expected an entry");
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("cpu_instr",   cpu_instr,           e.instr);
                chk("fetch_fault", 32'(fetch_fault),    32'(e.fault));
                chk("cpu_run",     32'(cpu_run),        32'(e.run));
                chk("ld_ready",    32'(ld_ready),       32'(e.ready));
                chk("ld_count",    32'(ld_count),       32'(e.count));
                chk("ld_err",      32'(ld_err),         32'(e.err));
            end
        end
    end

    task automatic model_reset();
        m_phase = M_CLEAR;
        m_cnt   = 0;
        m_err   = 1'b0;
    endtask

    task automatic model_clear_done();
        for (int i = 0; i < DEPTH; i++) m_mem[i] = NOP;
        m_phase = M_LOAD;
        m_cnt   = 0;
    endtask

    // One clock of host activity as the model sees it.
    task automatic model_apply(input logic v, input logic [31:0] a, input logic [31:0] d,
                               input logic dn, input logic lr);
        case (m_phase)
            M_LOAD: begin
                if (v) begin
                    if (a < 32'(DEPTH)) begin
                        m_mem[a[9:0]] = d;
                        if (m_cnt < DEPTH) m_cnt++;
                    end else begin
                        m_err = 1'b1;
                    end
                end
                if (dn) m_phase = M_RUN;
            end
            M_RUN: begin
                if (lr) begin
                    m_phase = M_LOAD;
                    m_cnt   = 0;
                end
            end
            default: ;
        endcase
    endtask

    // Queue the model's view of the outputs and let the monitor sample at the next negedge.
    task automatic observe();
        exp_t e;
        e.run   = (m_phase == M_RUN);
        e.ready = (m_phase == M_LOAD);
        e.count = 11'(m_cnt);
        e.err   = m_err;
        e.fault = e.run && (cpu_pc >= 32'(DEPTH));
        if (e.run && !e.fault) e.instr = m_mem[cpu_pc[9:0]];
        else                   e.instr = NOP;
        exp_q.push_back(e);
        obs_vld = 1'b1;
        @(negedge clk);
        #1;
        obs_vld = 1'b0;
    endtask

    // Drive one cycle of host inputs, advance past the edge, then drop the pulses.
    task automatic step(input logic v, input logic [31:0] a, input logic [31:0] d,
                        input logic dn, input logic lr);
        ld_valid = v;
        ld_addr  = a;
        ld_data  = d;
        ld_done  = dn;
        load_req = lr;
        model_apply(v, a, d, dn, lr);
        @(posedge clk);
        #1;
        ld_valid = 1'b0;
        ld_done  = 1'b0;
        load_req = 1'b0;
    endtask

    task automatic idle();
        step(1'b0, $urandom, $urandom, 1'b0, 1'b0);
    endtask

    // Walk through CLEAR, checking every cycle; ncyc < DEPTH stops early.
    task automatic run_clear(input int ncyc);
        for (int k = 1; k <= ncyc; k++) begin
            cpu_pc = $urandom_range(0, 2047);
            @(posedge clk);
            #1;
            if (k == DEPTH) model_clear_done();
            observe();
        end
    endtask

    task automatic fetch(input logic [31:0] pc);
        cpu_pc = pc;
        observe();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset    = 1'b1;
        load_req = 1'b0;
        ld_valid = 1'b0;
        ld_addr  = '0;
        ld_data  = '0;
        ld_done  = 1'b0;
        cpu_pc   = 32'd1;
        model_reset();

        // Reset state.
        repeat (3) @(posedge clk);
        #1;
        observe();
        reset = 1'b0;

        // Full clear after reset release.
        run_clear(DEPTH);

        // Directed program load with gaps.
        step(1'b1, 32'd0, 32'h214A_0005, 1'b0, 1'b0);
        idle();
        step(1'b1, 32'd1, 32'h2129_0001, 1'b0, 1'b0);
        step(1'b1, 32'd2, 32'h112A_0001, 1'b0, 1'b0);
        idle();
        step(1'b0, 32'd9, 32'h0, 1'b0, 1'b1);
        step(1'b1, 32'd3, 32'h0800_0001, 1'b0, 1'b0);
        observe();
        step(1'b1, 32'd2000, 32'h1234_5678, 1'b0, 1'b0);
        observe();
        idle();
        observe();
        step(1'b1, 32'd5, 32'hAC0B_03FF, 1'b1, 1'b0);
        observe();
        fetch(32'd1);
        fetch(32'd7);
        fetch(32'd2000);
        fetch(32'd5);
        fetch(32'd1023);
        fetch(32'd1024);
        for (int i = 0; i < 4; i++) fetch(32'(i));

        // Loader activity in RUN must be ignored.
        step(1'b1, 32'd0, 32'hDEAD_BEEF, 1'b1, 1'b0);
        fetch(32'd0);

        // Re-enter LOAD, patch word 4, back to RUN.
        step(1'b0, 32'd0, 32'd0, 1'b0, 1'b1);
        observe();
        step(1'b1, 32'd4, 32'h216B_0064, 1'b0, 1'b0);
        step(1'b0, 32'd0, 32'd0, 1'b1, 1'b0);
        observe();
        for (int i = 0; i < 6; i++) fetch(32'(i));

        // Randomized load/fetch rounds.
        for (int r = 0; r < 5; r++) begin
            step(1'b0, 32'd0, 32'd0, 1'b0, 1'b1);
            observe();
            for (int n = 0; n < 20; n++) begin
                if ($urandom_range(0, 3) == 0) begin
                    step(1'b0, $urandom, $urandom, 1'b0, 1'($urandom_range(0, 1)));
                end else begin
                    step(1'b1, 32'($urandom_range(0, 1100)), $urandom, 1'b0, 1'b0);
                end
                if ($urandom_range(0, 2) == 0) observe();
            end
            step(1'($urandom_range(0, 1)), 32'($urandom_range(0, 1023)), $urandom, 1'b1, 1'b0);
            observe();
            for (int f = 0; f < 15; f++) begin
                if ($urandom_range(0, 4) == 0) fetch($urandom);
                else                           fetch(32'($urandom_range(0, 1023)));
            end
        end

        // Count saturation at DEPTH.
        step(1'b0, 32'd0, 32'd0, 1'b0, 1'b1);
        for (int i = 0; i < DEPTH + 6; i++) begin
            step(1'b1, 32'(i % DEPTH), $urandom, 1'b0, 1'b0);
        end
        observe();
        step(1'b0, 32'd0, 32'd0, 1'b1, 1'b0);
        for (int f = 0; f < 8; f++) fetch(32'($urandom_range(0, 1023)));

        // Ensure the sticky error is set before testing that reset clears it.
        step(1'b0, 32'd0, 32'd0, 1'b0, 1'b1);
        step(1'b1, 32'd5000, 32'h0, 1'b1, 1'b0);
        observe();

        // Reset mid-RUN, then reset again partway through CLEAR.
        reset = 1'b1;
        model_reset();
        observe();
        reset = 1'b0;
        run_clear(500);
        reset = 1'b1;
        model_reset();
        observe();
        @(posedge clk);
        #1;
        reset = 1'b0;
        run_clear(DEPTH);

        // Everything written before reset must read back as NOP.
        step(1'b0, 32'd0, 32'd0, 1'b1, 1'b0);
        observe();
        for (int i = 0; i < 8; i++) fetch(32'(i));
        fetch(32'(DEPTH - 1));

        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_leftover: got %0d entries expected 0", exp_q.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
